// File: rtl/rvfi_imem_pkg.sv
// Shared types and constants for the RVFI instruction-memory responder.
// Holds the queued fetch entry layout and the age/latency limits.
package rvfi_imem_pkg;

    localparam int AGE_W       = 4;
    localparam int MAX_LATENCY = 15;
    // Widest fetch address an entry can carry; narrower XLEN is zero-extended.
    localparam int ADDR_W_MAX  = 64;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [31:0]           data;
        logic                  err;
        logic [AGE_W-1:0]      age;
    } imem_entry_t;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == '1) ? a : a + AGE_W'(1);
    endfunction

endpackage

// File: rtl/rvfi_imem_responder_if.sv
// Request/response handshake bundle between a fetch unit and the responder.
// The master issues fetches and consumes responses; the slave answers them.
interface rvfi_imem_responder_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_addr;
    logic [31:0]     rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_err
    );
endinterface

// File: rtl/rvfi_imem_fifo.sv
// In-order queue of outstanding fetches; every stored entry ages by one
// (saturating) each cycle so the responder can enforce a minimum latency.
module rvfi_imem_fifo
    import rvfi_imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  imem_entry_t            wr_entry,
    output imem_entry_t            head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    imem_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Only the age field is control state; payload fields are left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!resetn)
                mem[i].age <= '0;
            else if (push && wr_ptr == PTR_W'(i))
                mem[i] <= wr_entry;
            else
                mem[i].age <= age_inc(mem[i].age);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rvfi_imem_responder.sv
// Instruction-fetch responder for formal/RVFI harnesses: serves one probed
// halfword from imem_data and fills every other lane with free_data.
module rvfi_imem_responder
    import rvfi_imem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [XLEN-1:0]       imem_addr,
    input  logic [15:0]           imem_data,
    input  logic [31:0]           free_data,
    input  logic                  stall,
    rvfi_imem_responder_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    imem_entry_t      wr_entry;
    imem_entry_t      head;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             retire;
    logic             nonempty;
    logic             ripe;
    logic             rsp_hold;
    logic             rsp_valid;
    logic [15:0]      lo_half;
    logic [15:0]      hi_half;
    logic             unused_head_bits;

    assign bus.req_ready = resetn && (count < CNT_W'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign retire        = rsp_valid && bus.rsp_ready;
    assign nonempty      = (count != '0);

    // The probed halfword may land in either lane; the +2 wraps modulo 2^XLEN.
    assign lo_half = (bus.req_addr == imem_addr) ? imem_data : free_data[15:0];
    assign hi_half = ((bus.req_addr + XLEN'(2)) == imem_addr) ? imem_data : free_data[31:16];

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = ADDR_W_MAX'(bus.req_addr);
        wr_entry.data = {hi_half, lo_half};
        wr_entry.err  = bus.req_addr[0];
        wr_entry.age  = '0;
    end

    rvfi_imem_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (accept),
        .pop      (retire),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    // Stored age counts edges since the accept edge, so age LATENCY-1 means
    // the request was accepted LATENCY cycles ago.
    assign ripe = head.age >= AGE_W'(LATENCY - 1);

    // Stall only gates the rise; once presented, a response is held to retire.
    assign rsp_valid = resetn && nonempty && (rsp_hold || (ripe && !stall));

    always_ff @(posedge clk) begin
        if (!resetn || retire)
            rsp_hold <= 1'b0;
        else if (rsp_valid)
            rsp_hold <= 1'b1;
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_addr  = nonempty ? head.addr[XLEN-1:0] : '0;
    assign bus.rsp_data  = nonempty ? head.data : '0;
    assign bus.rsp_err   = nonempty ? head.err : 1'b0;

    assign unused_head_bits = ^head.addr;

endmodule

// File: tb/tb_rvfi_imem_responder.sv
// Bench for rvfi_imem_responder: a LATENCY=1 and a LATENCY=3 instance, each
// with an in-order scoreboard of expected responses.
module tb_rvfi_imem_responder;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    localparam logic [31:0] IMEM_A = 32'h0000_0100;
    localparam logic [31:0] IMEM_B = 32'h0000_0000;
    localparam logic [15:0] IMEM_D = 16'hABCD;

    logic        clk;
    logic        resetn;
    logic [31:0] free_a;
    logic [31:0] free_b;
    logic        stall_a;
    logic        stall_b;
    int          checks;
    int          errors;
    exp_t        sb_a[$];
    exp_t        sb_b[$];

    rvfi_imem_responder_if #(.XLEN(32)) ifa ();
    rvfi_imem_responder_if #(.XLEN(32)) ifb ();

    rvfi_imem_responder #(.XLEN(32), .DEPTH(4), .LATENCY(1)) dut_a (
        .clk       (clk),
        .resetn    (resetn),
        .imem_addr (IMEM_A),
        .imem_data (IMEM_D),
        .free_data (free_a),
        .stall     (stall_a),
        .bus       (ifa)
    );

    rvfi_imem_responder #(.XLEN(32), .DEPTH(4), .LATENCY(3)) dut_b (
        .clk       (clk),
        .resetn    (resetn),
        .imem_addr (IMEM_B),
        .imem_data (IMEM_D),
        .free_data (free_b),
        .stall     (stall_b),
        .bus       (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] im_a,
                                   input logic [31:0] fd);
        exp_t e;
        e.addr       = a;
        e.err        = a[0];
        e.data[15:0] = (a == im_a) ? IMEM_D : fd[15:0];
        e.data[31:16] = ((a + 32'd2) == im_a) ? IMEM_D : fd[31:16];
        return e;
    endfunction

    task automatic step_a();
        exp_t e;
        exp_t got;
        @(negedge clk);
        if (resetn && ifa.req_valid && ifa.req_ready)
            sb_a.push_back(model(ifa.req_addr, IMEM_A, free_a));
        if (ifa.rsp_valid && ifa.rsp_ready) begin
            checks++;
            got = '{addr: ifa.rsp_addr, data: ifa.rsp_data, err: ifa.rsp_err};
            if (sb_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_rsp got addr=%h data=%h, expected no response",
                         got.addr, got.data);
            end else begin
                e = sb_a.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL a_scoreboard got addr=%h data=%h err=%b exp addr=%h data=%h err=%b",
                             got.addr, got.data, got.err, e.addr, e.data, e.err);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_b();
        exp_t e;
        exp_t got;
        @(negedge clk);
        if (resetn && ifb.req_valid && ifb.req_ready)
            sb_b.push_back(model(ifb.req_addr, IMEM_B, free_b));
        if (ifb.rsp_valid && ifb.rsp_ready) begin
            checks++;
            got = '{addr: ifb.rsp_addr, data: ifb.rsp_data, err: ifb.rsp_err};
            if (sb_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_rsp got addr=%h data=%h, expected no response",
                         got.addr, got.data);
            end else begin
                e = sb_b.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL b_scoreboard got addr=%h data=%h err=%b exp addr=%h data=%h err=%b",
                             got.addr, got.data, got.err, e.addr, e.data, e.err);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step_a();
        step_a();
        checks++;
        if (ifa.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready got %b exp 0", ifa.req_ready);
        end
        checks++;
        if ({ifa.rsp_valid, ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_rsp got valid=%b addr=%h data=%h err=%b exp all 0",
                     ifa.rsp_valid, ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err);
        end
        resetn = 1'b1;
        step_a();
        checks++;
        if (ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got a=%b b=%b exp 1", ifa.req_ready, ifb.req_ready);
        end
    endtask

    task automatic test_data_lanes();
        ifa.rsp_ready = 1'b1;
        ifa.req_valid = 1'b1;
        ifa.req_addr  = 32'h100;
        free_a        = 32'h1234_5678;
        step_a();
        checks++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_data !== 32'h1234_ABCD || ifa.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL lane_low got valid=%b data=%h err=%b exp 1 1234abcd 0",
                     ifa.rsp_valid, ifa.rsp_data, ifa.rsp_err);
        end
        ifa.req_addr = 32'h0FE;
        step_a();
        checks++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_data !== 32'hABCD_5678) begin
            errors++;
            $display("FAIL lane_high got valid=%b data=%h exp 1 abcd5678", ifa.rsp_valid, ifa.rsp_data);
        end
        ifa.req_addr = 32'h0FC;
        step_a();
        checks++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lane_none got valid=%b data=%h exp 1 12345678", ifa.rsp_valid, ifa.rsp_data);
        end
        ifa.req_valid = 1'b0;
        step_a();
        checks++;
        if ({ifa.rsp_valid, ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err} !== '0) begin
            errors++;
            $display("FAIL empty_outputs got valid=%b addr=%h data=%h err=%b exp all 0",
                     ifa.rsp_valid, ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err);
        end
    endtask

    task automatic test_backpressure();
        ifa.rsp_ready = 1'b0;
        ifa.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifa.req_addr = 32'h200 + 32'(i * 4);
            free_a       = $urandom();
            checks++;
            if (ifa.req_ready !== (i < 4)) begin
                errors++;
                $display("FAIL fill_ready req %0d got %b exp %b", i, ifa.req_ready, (i < 4));
            end
            step_a();
        end
        ifa.req_valid = 1'b0;
        checks++;
        if (sb_a.size() != 4 || ifa.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state got accepted=%0d ready=%b exp 4 0", sb_a.size(), ifa.req_ready);
        end
        ifa.rsp_ready = 1'b1;
        step_a();
        for (int c = 0; c < 12 && sb_a.size() != 0; c++) step_a();
        checks++;
        if (sb_a.size() != 0 || ifa.req_ready !== 1'b1 || ifa.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got left=%0d ready=%b valid=%b exp 0 1 0",
                     sb_a.size(), ifa.req_ready, ifa.rsp_valid);
        end
    endtask

    task automatic test_misaligned();
        ifa.rsp_ready = 1'b1;
        ifa.req_valid = 1'b1;
        ifa.req_addr  = 32'h101;
        free_a        = 32'hCAFE_F00D;
        step_a();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b1 || ifa.rsp_addr !== 32'h101 ||
            ifa.rsp_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL misaligned got valid=%b err=%b addr=%h data=%h exp 1 1 101 cafef00d",
                     ifa.rsp_valid, ifa.rsp_err, ifa.rsp_addr, ifa.rsp_data);
        end
        step_a();
    endtask

    task automatic test_addr_wrap();
        int k;
        ifb.rsp_ready = 1'b1;
        ifb.req_valid = 1'b1;
        ifb.req_addr  = 32'hFFFF_FFFE;
        free_b        = 32'h1111_2222;
        step_b();
        ifb.req_valid = 1'b0;
        k = 1;
        while (ifb.rsp_valid !== 1'b1 && k < 8) begin
            step_b();
            k++;
        end
        checks++;
        if (k != 3) begin
            errors++; $display("FAIL latency3 got %0d cycles exp 3", k);
        end
        checks++;
        if (ifb.rsp_data !== 32'hABCD_2222 || ifb.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_wrap got data=%h err=%b exp abcd2222 0", ifb.rsp_data, ifb.rsp_err);
        end
        step_b();
    endtask

    task automatic test_stall();
        ifb.rsp_ready = 1'b0;
        stall_b       = 1'b0;
        ifb.req_valid = 1'b1;
        ifb.req_addr  = 32'h300;
        free_b        = 32'h55AA_55AA;
        step_b();
        ifb.req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            stall_b = 1'b1;
            #1;
            checks++;
            if (ifb.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL stall_block cycle t+%0d got valid=%b exp 0", k, ifb.rsp_valid);
            end
            step_b();
        end
        stall_b = 1'b0;
        #1;
        checks++;
        if (ifb.rsp_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release got valid=%b exp 1 at t+6", ifb.rsp_valid);
        end
        step_b();
        stall_b = 1'b1;
        #1;
        checks++;
        if (ifb.rsp_valid !== 1'b1 || ifb.rsp_addr !== 32'h300 || ifb.rsp_data !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL stall_hold got valid=%b addr=%h data=%h exp 1 300 55aa55aa",
                     ifb.rsp_valid, ifb.rsp_addr, ifb.rsp_data);
        end
        ifb.rsp_ready = 1'b1;
        step_b();
        stall_b = 1'b0;
        #1;
        checks++;
        if (ifb.rsp_valid !== 1'b0 || sb_b.size() != 0) begin
            errors++;
            $display("FAIL stall_retire got valid=%b left=%0d exp 0 0", ifb.rsp_valid, sb_b.size());
        end
    endtask

    task automatic test_back_to_back();
        int accepted;
        accepted      = 0;
        ifa.req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            case ($urandom_range(0, 3))
                0:       ifa.req_addr = 32'h100;
                1:       ifa.req_addr = 32'h0FE;
                2:       ifa.req_addr = 32'h101;
                default: ifa.req_addr = 32'h400 + 32'($urandom_range(0, 255)) * 32'd2;
            endcase
            free_a        = $urandom();
            ifa.rsp_ready = ($urandom_range(0, 3) != 0);
            if (ifa.req_ready) accepted++;
            step_a();
        end
        ifa.req_valid = 1'b0;
        ifa.rsp_ready = 1'b1;
        for (int c = 0; c < 12 && sb_a.size() != 0; c++) step_a();
        checks++;
        if (sb_a.size() != 0 || ifa.rsp_valid !== 1'b0 || accepted <= 4) begin
            errors++;
            $display("FAIL back_to_back got left=%0d valid=%b accepted=%0d exp 0 0 >4",
                     sb_a.size(), ifa.rsp_valid, accepted);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale         = 0;
        ifa.rsp_ready = 1'b0;
        ifa.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.req_addr = 32'h500 + 32'(i * 4);
            free_a       = $urandom();
            step_a();
        end
        ifa.req_addr = 32'h50C;
        resetn       = 1'b0;
        #1;
        checks++;
        if (ifa.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_blocks_accept got ready=%b exp 0", ifa.req_ready);
        end
        step_a();
        sb_a.delete();
        sb_b.delete();
        resetn        = 1'b1;
        ifa.req_valid = 1'b0;
        ifa.rsp_ready = 1'b1;
        #1;
        checks++;
        if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flush got valid=%b ready=%b exp 0 1", ifa.rsp_valid, ifa.req_ready);
        end
        for (int c = 0; c < 8; c++) begin
            if (ifa.rsp_valid !== 1'b0) stale++;
            step_a();
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL stale_response got %0d stale cycles exp 0", stale);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        resetn        = 1'b0;
        free_a        = '0;
        free_b        = '0;
        stall_a       = 1'b0;
        stall_b       = 1'b0;
        ifa.req_valid = 1'b0;
        ifa.req_addr  = '0;
        ifa.rsp_ready = 1'b0;
        ifb.req_valid = 1'b0;
        ifb.req_addr  = '0;
        ifb.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_data_lanes();
        test_backpressure();
        test_misaligned();
        test_addr_wrap();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_imem_responder.md
RVFI_IMEM_RESPONDER -- requirements
Module: rvfi_imem_responder

Interface
REQ-001 Parameter XLEN, 32, address width of fetch and probe addresses.
REQ-002 Parameter DEPTH, 4, maximum outstanding fetches; power of 2, at least 2.
REQ-003 Parameter LATENCY, 1, minimum cycles from request accept to response valid; range 1..15.
REQ-004 Port clk  in  1  clock; all state updates on its rising edge.
REQ-005 Port resetn  in  1  reset, synchronous, active-low.
REQ-006 Port imem_addr  in  XLEN  probe halfword address; held constant for the whole run.
REQ-007 Port imem_data  in  16  halfword value served at imem_addr; held constant for the whole run.
REQ-008 Port free_data  in  32  arbitrary filler word, sampled at request accept.
REQ-009 Port stall  in  1  when high, blocks a new response from becoming valid.
REQ-010 Port req_valid  in  1  fetch request present.
REQ-011 Port req_ready  out  1  responder can accept a request.
REQ-012 Port req_addr  in  XLEN  fetch address.
REQ-013 Port rsp_valid  out  1  response present.
REQ-014 Port rsp_ready  in  1  consumer takes the response.
REQ-015 Port rsp_addr  out  XLEN  address of the request being answered.
REQ-016 Port rsp_data  out  32  fetched instruction word.
REQ-017 Port rsp_err  out  1  request address was odd (misaligned).

Function
REQ-018 A request is accepted on a cycle where req_valid and req_ready are both high; a response retires on a cycle where rsp_valid and rsp_ready are both high.
REQ-019 req_ready is high exactly when the occupancy count is below DEPTH; a retire at full does not raise req_ready in the same cycle.
REQ-020 Accepted requests are answered strictly in acceptance order, one response per request.
REQ-021 Each entry holds addr, data, err and a saturating 4-bit age; age is 0 at accept and increments each cycle.
REQ-022 rsp_valid rises only when the queue is non-empty, head age >= LATENCY, and stall is low; with LATENCY=1 and no stall, a request accepted in cycle t is valid in cycle t+1.
REQ-023 Once rsp_valid is high, it stays high and rsp_addr, rsp_data and rsp_err stay stable until retire, regardless of stall.
REQ-024 Low halfword of data is imem_data if req_addr == imem_addr, else free_data[15:0].
REQ-025 High halfword of data is imem_data if req_addr+2 == imem_addr (modulo 2^XLEN), else free_data[31:16].
REQ-026 err is req_addr[0]; data is still formed per REQ-024/025.
REQ-027 Simultaneous accept and retire leaves occupancy unchanged; both pointers wrap modulo DEPTH.
REQ-028 While the queue is empty, rsp_valid is low and rsp_addr/rsp_data/rsp_err are 0.

Reset
REQ-029 While resetn is low at a clock edge: occupancy, pointers and ages clear; rsp_valid=0; rsp_addr/rsp_data/rsp_err=0.
REQ-030 Outstanding requests are discarded by reset, including one mid-handshake; req_ready is 1 on the first cycle after reset deasserts.
REQ-031 No request is accepted while resetn is low, and req_ready is driven 0 during reset.

Structure
REQ-032 Package rvfi_imem_pkg holds the entry struct type (addr, data, err, age) and the age-width and maximum-LATENCY constants.
REQ-033 Queue storage and pointers live in sub-module rvfi_imem_fifo; lane selection and handshake logic live in the top.

Verification
REQ-034 imem_addr=0x100, imem_data=0xABCD, free_data=0x12345678, request 0x100, LATENCY=1 -> next cycle rsp_data=0x1234ABCD, rsp_err=0.
REQ-035 Same setup, request 0x0FE -> rsp_data=0xABCD5678; request 0x0FC -> rsp_data=0x12345678.
REQ-036 DEPTH=4, rsp_ready=0, 5 back-to-back requests -> 4 accepted, req_ready=0 on the 5th; drain -> responses in order, then req_ready=1.
REQ-037 LATENCY=3, stall=1 for cycles t+1..t+5 on a request accepted at t -> rsp_valid first high at t+6; raising stall after rsp_valid does not drop it.
REQ-038 Request 0x101 -> rsp_err=1, rsp_addr=0x101; request 0xFFFFFFFE with imem_addr=0x0 -> high halfword equals imem_data.
REQ-039 resetn=0 for one cycle with 3 outstanding requests -> rsp_valid=0 next cycle, req_ready=1, no stale response ever appears.
